// File: rtl/game_tick_pkg.sv
// Shared types, default constants and the level-to-period mapping
// used by the game tick controller.
package game_tick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned DEF_BASE_DIV = 2000000;
  localparam int unsigned DEF_DIV_STEP = 200000;
  localparam int unsigned DEF_MIN_DIV  = 400000;
  localparam int unsigned DEF_LEVELS   = 8;
  localparam int unsigned DEF_CNT_W    = 22;
  localparam int unsigned DEF_LVL_W    = 3;

  // Tick period for a level: base minus per-level reduction, clamped to min
  function automatic int unsigned period_of(input int unsigned lvl,
                                            input int unsigned base_div,
                                            input int unsigned div_step,
                                            input int unsigned min_div);
    int unsigned red;
    red = lvl * div_step;
    if (red >= base_div) return min_div;
    if (base_div - red < min_div) return min_div;
    return base_div - red;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable period counter: counts while enabled, wraps at the active
// period and emits a registered one-cycle pulse on wrap or forced fire.
module tick_counter
  import game_tick_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned BASE_DIV = DEF_BASE_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             fire,
  input  logic [CNT_W-1:0] period_in,
  output logic             at_end_c,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_period;

  assign at_end_c = (cnt == active_period - CNT_W'(1));

  // Period reload happens only on explicit load or at a wrap boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      active_period <= CNT_W'(BASE_DIV);
      wrap          <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) active_period <= period_in;
      if (clr) begin
        cnt <= '0;
      end else if (fire) begin
        cnt  <= '0;
        wrap <= 1'b1;
      end else if (en) begin
        if (at_end_c) begin
          cnt           <= '0;
          wrap          <= 1'b1;
          active_period <= period_in;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/game_tick_ctrl.sv
// Run/pause/step controller and level-programmable game tick generator
// producing a single-cycle tick enable.
module game_tick_ctrl
  import game_tick_pkg::*;
#(
  parameter int unsigned BASE_DIV = DEF_BASE_DIV,
  parameter int unsigned DIV_STEP = DEF_DIV_STEP,
  parameter int unsigned MIN_DIV  = DEF_MIN_DIV,
  parameter int unsigned LEVELS   = DEF_LEVELS,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned LVL_W    = DEF_LVL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause_toggle,
  input  logic             step,
  input  logic             speed_up,
  input  logic             speed_rst,
  output logic             tick,
  output logic [LVL_W-1:0] level,
  output logic             running,
  output logic             paused
);

  state_t           state;
  state_t           state_next_c;
  logic [LVL_W-1:0] level_next_c;
  logic [LVL_W-1:0] period_lvl_c;
  logic [CNT_W-1:0] period_c;
  logic             cnt_en_c;
  logic             cnt_clr_c;
  logic             cnt_load_c;
  logic             step_fire_c;
  logic             at_end_c;

  // Command decode with priority stop > start > pause_toggle > step
  always_comb begin
    state_next_c = state;
    cnt_en_c     = 1'b0;
    cnt_clr_c    = 1'b0;
    cnt_load_c   = 1'b0;
    step_fire_c  = 1'b0;
    level_next_c = level;

    if (speed_rst) begin
      level_next_c = '0;
    end else if (speed_up && (level != LVL_W'(LEVELS - 1))) begin
      level_next_c = level + LVL_W'(1);
    end

    if (stop) begin
      state_next_c = IDLE;
      cnt_clr_c    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clr_c = 1'b1;
          if (start) begin
            state_next_c = RUN;
            cnt_load_c   = 1'b1;
          end
        end
        RUN: begin
          // A pause freezes the count, but a wrap in the same cycle still fires
          cnt_en_c = !pause_toggle || at_end_c;
          if (pause_toggle) state_next_c = PAUSE;
        end
        PAUSE: begin
          if (pause_toggle) state_next_c = RUN;
          else if (step) step_fire_c = 1'b1;
        end
        default: begin
          state_next_c = IDLE;
          cnt_clr_c    = 1'b1;
        end
      endcase
    end

    period_lvl_c = (state == IDLE) ? level_next_c : level;
    period_c     = CNT_W'(period_of(32'(period_lvl_c), BASE_DIV, DIV_STEP, MIN_DIV));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      level   <= '0;
      running <= 1'b0;
      paused  <= 1'b0;
    end else begin
      state   <= state_next_c;
      level   <= level_next_c;
      running <= (state_next_c == RUN);
      paused  <= (state_next_c == PAUSE);
    end
  end

  tick_counter #(
    .CNT_W   (CNT_W),
    .BASE_DIV(BASE_DIV)
  ) u_tick_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en_c),
    .clr      (cnt_clr_c),
    .load     (cnt_load_c),
    .fire     (step_fire_c),
    .period_in(period_c),
    .at_end_c (at_end_c),
    .wrap     (tick)
  );

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Bench for game_tick_ctrl: directed command sequence, a cycle model of the
// controller's rules compared every cycle, plus hand-computed tick spacings.
module tb_game_tick_ctrl;

  localparam int BASE   = 10;
  localparam int DSTEP  = 2;
  localparam int MINP   = 4;
  localparam int LEVELS = 5;

  localparam logic [6:0] C_RST   = 7'b0000001;
  localparam logic [6:0] C_SRST  = 7'b0000010;
  localparam logic [6:0] C_UP    = 7'b0000100;
  localparam logic [6:0] C_STEP  = 7'b0001000;
  localparam logic [6:0] C_PAUSE = 7'b0010000;
  localparam logic [6:0] C_START = 7'b0100000;
  localparam logic [6:0] C_STOP  = 7'b1000000;

  logic       clk;
  logic       rst, start, stop, pause_toggle, step, speed_up, speed_rst;
  logic       tick, running, paused;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Model state: mode 0 idle, 1 run, 2 pause; elapsed cycles in interval
  int m_mode, m_elapsed, m_period, m_lvl, m_tick;

  game_tick_ctrl #(
    .BASE_DIV(BASE), .DIV_STEP(DSTEP), .MIN_DIV(MINP), .LEVELS(LEVELS),
    .CNT_W(4), .LVL_W(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pause_toggle(pause_toggle), .step(step), .speed_up(speed_up),
    .speed_rst(speed_rst), .tick(tick), .level(level),
    .running(running), .paused(paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_of(input int l);
    int p;
    p = BASE - l * DSTEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int nl;
    if (rst) begin
      m_mode = 0; m_elapsed = 0; m_lvl = 0; m_period = BASE; m_tick = 0;
    end else begin
      if (speed_rst) nl = 0;
      else if (speed_up) nl = (m_lvl + 1 > LEVELS - 1) ? LEVELS - 1 : m_lvl + 1;
      else nl = m_lvl;
      m_tick = 0;
      if (stop) begin
        m_mode = 0; m_elapsed = 0;
      end else if (m_mode == 0) begin
        if (start) begin m_mode = 1; m_elapsed = 0; m_period = p_of(nl); end
      end else if (m_mode == 1) begin
        if (m_elapsed + 1 == m_period) begin
          m_tick = 1; m_elapsed = 0; m_period = p_of(m_lvl);
        end else if (!pause_toggle) begin
          m_elapsed++;
        end
        if (pause_toggle) m_mode = 2;
      end else begin
        if (pause_toggle) m_mode = 1;
        else if (step) begin m_tick = 1; m_elapsed = 0; end
      end
      m_lvl = nl;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_tick", int'(tick), m_tick);
      chk("model_level", int'(level), m_lvl);
      chk("model_running", int'(running), int'(m_mode == 1));
      chk("model_paused", int'(paused), int'(m_mode == 2));
    end
  end

  task automatic drive(input logic [6:0] c);
    {stop, start, pause_toggle, step, speed_up, speed_rst, rst} = c;
    @(negedge clk);
    {stop, start, pause_toggle, step, speed_up, speed_rst, rst} = '0;
  endtask

  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 100);
  endtask

  task automatic count_ticks(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tick) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    {stop, start, pause_toggle, step, speed_up, speed_rst, rst} = '0;

    // Reset and basic run
    drive(C_RST);
    chk_en = 1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_paused", int'(paused), 0);
    drive(C_START);
    chk("start_running", int'(running), 1);
    cycles_to_tick(n); chk("first_tick", n, 10);
    cycles_to_tick(n); chk("tick2", n, 10);
    cycles_to_tick(n); chk("tick3", n, 10);

    // Level change applies at the next wrap only
    repeat (5) @(negedge clk);
    drive(C_UP);
    chk("level1", int'(level), 1);
    cycles_to_tick(n); chk("old_interval", n, 4);
    cycles_to_tick(n); chk("lvl1_interval", n, 8);
    repeat (4) drive(C_UP);
    chk("level_sat", int'(level), 4);
    cycles_to_tick(n); chk("lvl1_carry", n, 4);
    cycles_to_tick(n); chk("min_period", n, 4);
    drive(C_SRST);
    chk("level_rst", int'(level), 0);
    cycles_to_tick(n); chk("min_tail", n, 3);

    // Pause at cnt = 3 and resume
    repeat (3) @(negedge clk);
    drive(C_PAUSE);
    chk("paused_on", int'(paused), 1);
    count_ticks(50, n); chk("pause_no_tick", n, 0);
    drive(C_PAUSE);
    chk("resume_paused", int'(paused), 0);
    chk("resume_running", int'(running), 1);
    cycles_to_tick(n); chk("resume_tick", n, 7);
    cycles_to_tick(n); chk("resume_interval", n, 10);

    // Single-step while paused
    repeat (2) @(negedge clk);
    drive(C_PAUSE);
    drive(C_STEP);
    chk("step_tick", int'(tick), 1);
    drive(C_STEP);
    chk("step_b2b", int'(tick), 1);
    @(negedge clk);
    chk("step_done", int'(tick), 0);
    drive(C_PAUSE);
    cycles_to_tick(n); chk("step_cnt_zero", n, 10);
    drive(C_STEP);
    chk("run_step_ignored", int'(tick), 0);
    cycles_to_tick(n); chk("run_step_interval", n, 9);

    // Stop coinciding with a wrap, stop beats start
    repeat (9) @(negedge clk);
    drive(C_STOP | C_START);
    chk("stop_wrap_tick", int'(tick), 0);
    chk("stop_running", int'(running), 0);
    count_ticks(30, n); chk("idle_no_tick", n, 0);
    drive(C_STEP);
    chk("idle_step", int'(tick), 0);
    drive(C_START | C_PAUSE);
    chk("start_pause_run", int'(running), 1);
    chk("start_pause_paused", int'(paused), 0);
    cycles_to_tick(n); chk("restart_tick", n, 10);

    // Reset mid-period at level 3
    repeat (3) drive(C_UP);
    chk("level3", int'(level), 3);
    repeat (4) @(negedge clk);
    drive(C_RST);
    chk("rst2_tick", int'(tick), 0);
    chk("rst2_level", int'(level), 0);
    chk("rst2_running", int'(running), 0);
    chk("rst2_paused", int'(paused), 0);
    drive(C_START);
    cycles_to_tick(n); chk("post_rst_tick", n, 10);
    cycles_to_tick(n); chk("post_rst_interval", n, 10);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_tick_ctrl.md
Name: game_tick_ctrl

Overview:
- Run/pause/step controller and programmable game-tick generator for the game logic; driven from the 100 MHz system clock.
- Produces a single-cycle clock-enable `tick` at a speed that depends on the current level, instead of a free-running divided clock.
- Sequences game time for the game FSM: idle, run, pause, single-step, and speed-level changes.
- Applies each period change only at a tick boundary, so no tick interval is ever shortened mid-flight.

Parameters:
- BASE_DIV, 2000000: tick period in clk cycles at level 0 (50 Hz).
- DIV_STEP, 200000: period reduction per level.
- MIN_DIV, 400000: lower clamp on the period; must be >= 2.
- LEVELS, 8: number of speed levels; valid levels are 0..LEVELS-1.
- CNT_W, 22: period counter width; must satisfy 2^CNT_W > BASE_DIV.
- LVL_W, 3: level width; must satisfy 2^LVL_W >= LEVELS.

Ports:
- clk, in, 1: system clock, 100 MHz.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: single-cycle pulse; IDLE -> RUN.
- stop, in, 1: single-cycle pulse; any state -> IDLE.
- pause_toggle, in, 1: single-cycle pulse; RUN <-> PAUSE.
- step, in, 1: single-cycle pulse; emits one tick while in PAUSE.
- speed_up, in, 1: single-cycle pulse; level + 1, saturating at LEVELS-1.
- speed_rst, in, 1: single-cycle pulse; level -> 0.
- tick, out, 1: registered one-cycle game enable.
- level, out, LVL_W: current speed level.
- running, out, 1: high in RUN.
- paused, out, 1: high in PAUSE.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state = IDLE; cnt = 0; level = 0; active_period = BASE_DIV.
  - tick = 0, running = 0, paused = 0, all from the next cycle.
  - rst overrides every other input, including when it arrives mid-period or mid-step.
- Period function: P(L) = max(BASE_DIV - L*DIV_STEP, MIN_DIV).
  - Computed at CNT_W+LVL_W bits with no wrap. Use a signed or guarded compare so that underflow clamps to MIN_DIV.
- active_period register:
  - Loads P(level_next) on entry to RUN from IDLE.
  - Loads P(level) on every RUN wrap.
  - Holds its value at all other times.
- Command priority when several pulses coincide: stop > start > pause_toggle > step.
  - Lower-priority commands in the same cycle are ignored.
- IDLE:
  - cnt held at 0; no ticks.
  - start -> RUN with cnt = 0.
  - pause_toggle and step are ignored.
- RUN:
  - cnt increments each cycle.
  - When cnt == active_period-1: cnt <= 0 and tick = 1 on the following cycle (registered).
  - The first tick is therefore seen exactly active_period cycles after the cycle in which start was sampled.
  - Tick spacing is exactly active_period cycles.
  - pause_toggle -> PAUSE with cnt frozen. If the wrap and pause_toggle coincide, the wrap tick is still issued.
  - step is ignored.
- PAUSE:
  - cnt frozen; no periodic ticks.
  - pause_toggle -> RUN; counting resumes from the frozen cnt.
  - step -> tick = 1 on the next cycle, cnt <= 0, state stays PAUSE.
  - Back-to-back step pulses give back-to-back ticks.
- stop from any state: IDLE, cnt = 0. A tick already registered in that cycle is suppressed, so tick is 0 in the next cycle.
- level:
  - speed_rst takes priority over speed_up.
  - Both are accepted in any state. The level output updates on the next cycle.
  - The period takes effect only at the next RUN wrap, or on IDLE -> RUN.
- Output decode: running = (state == RUN); paused = (state == PAUSE). Both are registered and state-decoded.
- Latency: every command changes its outputs one cycle after the pulse is sampled.

Decomposition:
- Package game_tick_pkg:
  - state enum: IDLE, RUN, PAUSE, 2-bit encoding.
  - Default constants BASE_DIV, DIV_STEP, MIN_DIV, LEVELS.
  - Function period_of(level) implementing P(L) with the clamp.
- One sub-module, tick_counter:
  - Loadable period counter with enable, clear, load_period and a registered wrap pulse.
  - The top level holds the FSM, the level register, command priority and tick muxing (wrap vs step).

Test Plan (BASE_DIV=10, DIV_STEP=2, MIN_DIV=4, LEVELS=5, CNT_W=4, LVL_W=3):
1. Reset, then start at cycle S -> ticks at S+10, S+20, S+30, each exactly one cycle wide; running = 1 from S+1.
2. speed_up when cnt = 5 -> level = 1 at the next cycle; the current interval is still 10; the following interval is 8. Then 4 more speed_up pulses -> level saturates at 4; period = max(2, 4) = 4.
3. pause_toggle at cnt = 3 -> paused = 1, no tick for 50 cycles; pause_toggle again -> next tick 7 cycles later, then every 10.
4. In PAUSE, step -> tick exactly one cycle later and cnt = 0. step in IDLE or RUN -> no extra tick.
5. stop and start in the same cycle during RUN -> IDLE, no ticks. start and pause_toggle together in IDLE -> RUN, not paused.
6. rst asserted mid-period with level = 3 -> next cycle: tick = 0, level = 0, running = 0, paused = 0. A later start gives a period of 10.
